proc_out_collector: RTL

- Read-side companion to the processor output strobes (outN / out_en).
- Captures each channel word on its enable pulse into a one-entry holding register per channel.
- Merges the channels through a round-robin arbiter into a shared first-word-fall-through FIFO.
- Presents the merged stream as tagged words on a valid/ready interface to downstream logging or a host bridge.
- Sticky per-channel overflow flags record any dropped words.

---
 rtl/proc_out_collector_if.sv | 32 +++
 rtl/proc_out_collector.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/proc_out_collector_if.sv
// Bundle of the channel capture inputs and the merged, tagged output stream
// of the processor output collector.
interface proc_out_collector_if #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CHW   = 2
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_en;
  logic [DW-1:0]     dout;
  logic [CHW-1:0]    dout_ch;
  logic              dout_valid;
  logic              dout_ready;
  logic [LW-1:0]     level;
  logic [NCH-1:0]    ovf;
  logic              clr_ovf;

  // Producer/consumer side: drives strobes and accepts the merged stream.
  modport master (
    output in_data, in_en, dout_ready, clr_ovf,
    input  dout, dout_ch, dout_valid, level, ovf
  );

  // Collector side.
  modport slave (
    input  in_data, in_en, dout_ready, clr_ovf,
    output dout, dout_ch, dout_valid, level, ovf
  );
endinterface

// File: rtl/proc_out_collector.sv
// Processor output collector: one holding register per channel, round-robin
// merge into a shared first-word-fall-through FIFO, tagged output stream and
// sticky per-channel overflow flags.
module proc_out_collector #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CHW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_geral,
  proc_out_collector_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CHW + DW;

  // Holding registers and bookkeeping
  logic [DW-1:0]    r_hold [NCH];
  logic [NCH-1:0]   r_hold_v;
  logic [NCH-1:0]   r_ovf;
  logic [CHW-1:0]   r_rr_ptr;

  // Shared FIFO storage; fullness comes from r_level, not pointer equality
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [DW-1:0]    r_dout;
  logic [CHW-1:0]   r_dout_ch;

  logic             w_valid;
  logic             w_pop;
  logic             w_can_write;
  logic             w_write;
  logic [2*NCH-1:0] w_req_dbl;
  logic [NCH-1:0]   w_req_rot;
  logic             w_req_any;
  logic [CHW-1:0]   w_off;
  logic [CHW:0]     w_gnt_sum;
  logic [CHW-1:0]   w_gnt;
  logic [CHW-1:0]   w_gnt_inc;
  logic [NCH-1:0]   w_gnt_vec;
  logic [NCH-1:0]   w_cap;
  logic [NCH-1:0]   w_ovf_evt;
  logic [EW-1:0]    w_wdata;
  logic [AW-1:0]    w_rd_next;
  logic [LW-1:0]    w_level_next;

  assign w_valid     = (r_level != '0);
  assign w_pop       = w_valid & bus.dout_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_can_write = (r_level != LW'(DEPTH)) | w_pop;

  // Rotate the request vector so that bit 0 is the channel at r_rr_ptr.
  assign w_req_dbl = {r_hold_v, r_hold_v} >> r_rr_ptr;
  assign w_req_rot = w_req_dbl[NCH-1:0];

  // Priority pick of the lowest rotated request (first channel from r_rr_ptr up).
  always_comb begin
    w_req_any = 1'b0;
    w_off     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_req_any = 1'b1;
        w_off     = CHW'(k);
      end
    end
  end

  assign w_gnt_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_gnt     = (w_gnt_sum >= (CHW+1)'(NCH)) ? CHW'(w_gnt_sum - (CHW+1)'(NCH))
                                                  : w_gnt_sum[CHW-1:0];
  assign w_gnt_inc = (w_gnt == CHW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
  assign w_write   = w_req_any & w_can_write;
  assign w_wdata   = {w_gnt, r_hold[w_gnt]};

  // Per-channel grant, capture and overflow decode. A granted channel frees
  // its holding register this cycle, so a new strobe on it is not a drop.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_gnt_vec[gi] = w_write & (w_gnt == CHW'(gi));
      assign w_cap[gi]     = bus.in_en[gi] & (~r_hold_v[gi] | w_gnt_vec[gi]);
      assign w_ovf_evt[gi] = bus.in_en[gi] & ~w_cap[gi];
    end
  endgenerate

  assign w_rd_next = r_rd_ptr + AW'(w_pop);

  // Occupancy after this cycle's write/pop.
  always_comb begin
    w_level_next = r_level;
    case ({w_write, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  // Holding registers: capture on strobe, release on grant.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      r_hold_v <= '0;
      for (int i = 0; i < NCH; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) begin
          r_hold[i]   <= bus.in_data[i*DW +: DW];
          r_hold_v[i] <= 1'b1;
        end else if (w_gnt_vec[i]) begin
          r_hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flags; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral)        r_ovf <= '0;
    else if (bus.clr_ovf) r_ovf <= w_ovf_evt;
    else                  r_ovf <= r_ovf | w_ovf_evt;
  end

  // Round-robin pointer moves past the granted channel only.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral)    r_rr_ptr <= '0;
    else if (w_write) r_rr_ptr <= w_gnt_inc;
  end

  // FIFO storage write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_wdata;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
    end
  end

  // Head register: preloads the word at the next read pointer, bypassing the
  // word written this cycle when it becomes the head; holds when empty.
  always_ff @(posedge clk or posedge rst_geral) begin
    if (rst_geral) begin
      r_dout    <= '0;
      r_dout_ch <= '0;
    end else if (w_level_next != '0) begin
      if (w_write && (w_rd_next == r_wr_ptr)) {r_dout_ch, r_dout} <= w_wdata;
      else                                    {r_dout_ch, r_dout} <= r_mem[w_rd_next];
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_valid = w_valid;
  assign bus.level      = r_level;
  assign bus.ovf        = r_ovf;
endmodule
